input_conditioner: RTL and testbench

Front-end conditioning for all player buttons and panel switches, directly upstream of the game top level and the game controller inside it. Each raw asynchronous pad input is synchronised into the 40 MHz domain and debounced into a clean level. The block also emits one-cycle press and release pulses, plus optional auto-repeat pulses for held direction buttons. All outputs are registered, so the controller never sees metastable or bouncing signals.

---
 rtl/breakout_pkg.sv | 35 +++
 rtl/input_conditioner_if.sv | 41 ++++
 rtl/debounce_channel.sv | 180 ++++++++++++++++++
 rtl/input_conditioner.sv | 56 +++++
 tb/tb_input_conditioner.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
// Shared constants for the button / switch front end and the game logic that
// consumes it.
//   - CH_* : bit index of each conditioned input within the channel vectors.
//   - DEF_*: default timing for a 40 MHz system clock.
//   - max_int(): compile-time helper used to size shared counters.
// -----------------------------------------------------------------------------
package breakout_pkg;

    localparam int NUM_CHANNELS    = 7;

    localparam int CH_LEFT         = 0;
    localparam int CH_RIGHT        = 1;
    localparam int CH_A            = 2;
    localparam int CH_B            = 3;
    localparam int CH_RESET        = 4;
    localparam int CH_PAUSE        = 5;
    localparam int CH_IGNORE_DEATH = 6;

    // 10 ms debounce, 300 ms first repeat, 100 ms repeat spacing at 40 MHz.
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 400000;
    localparam int DEF_REPEAT_DELAY    = 12000000;
    localparam int DEF_REPEAT_PERIOD   = 4000000;

    // Only the direction buttons auto-repeat.
    localparam logic [NUM_CHANNELS-1:0] DEF_REPEAT_MASK =
        (NUM_CHANNELS'(1) << CH_LEFT) | (NUM_CHANNELS'(1) << CH_RIGHT);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Bundles the raw pad inputs and the conditioned outputs of input_conditioner.
//   RAW_IN  : unsynchronised pad levels, 1 = pressed / on
//   LEVEL   : debounced level
//   PRESS   : one-cycle pulse on LEVEL 0->1
//   RELEASE : one-cycle pulse on LEVEL 1->0
//   REPEAT  : press pulse plus auto-repeat pulses (repeat-enabled channels)
// Modports:
//   master : the pad side / environment, drives RAW_IN
//   slave  : the conditioner, drives the conditioned outputs
// -----------------------------------------------------------------------------
interface input_conditioner_if
    import breakout_pkg::*;
#(
    parameter int CHANNELS = NUM_CHANNELS
);

    logic [CHANNELS-1:0] RAW_IN;
    logic [CHANNELS-1:0] LEVEL;
    logic [CHANNELS-1:0] PRESS;
    logic [CHANNELS-1:0] RELEASE;
    logic [CHANNELS-1:0] REPEAT;

    modport master (
        output RAW_IN,
        input  LEVEL,
        input  PRESS,
        input  RELEASE,
        input  REPEAT
    );

    modport slave (
        input  RAW_IN,
        output LEVEL,
        output PRESS,
        output RELEASE,
        output REPEAT
    );

endinterface

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One conditioned input: synchroniser chain, debounce counter, registered
// press/release pulses and an optional auto-repeat state machine.
//
// Ports:
//   CLK       : system clock
//   RESET     : asynchronous, active-high reset
//   raw_i     : unsynchronised pad level
//   level_o   : debounced level
//   press_o   : one-cycle pulse when level_o rises
//   release_o : one-cycle pulse when level_o falls
//   repeat_o  : press pulse plus auto-repeat pulses (0 when REPEAT_EN = 0)
//
// Auto-repeat states:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | level low or repeat disabled, waiting for a press
//   ST_DELAY   | held, counting down to the first repeat pulse
//   ST_PERIOD  | held, counting down between later repeat pulses
// -----------------------------------------------------------------------------
module debounce_channel
    import breakout_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: the level only follows s after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, release_q;
    logic            rise, fall;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (s == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Edge events of this cycle; the pulses are registered alongside LEVEL.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
    if (REPEAT_EN) begin : g_rpt
        localparam logic [1:0] ST_IDLE   = 2'd0;
        localparam logic [1:0] ST_DELAY  = 2'd1;
        localparam logic [1:0] ST_PERIOD = 2'd2;

        localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
        localparam logic [RPT_W-1:0] LOAD_DELAY  = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] LOAD_PERIOD = RPT_W'(REPEAT_PERIOD - 1);

        logic [1:0]       state_q, state_d;
        logic [RPT_W-1:0] rcnt_q, rcnt_d;
        logic             rep_q, rep_d;

        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rep_d   = 1'b0;
            // A fall pre-empts a repeat expiring in the same cycle.
            if (fall) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d = ST_DELAY;
                            rcnt_d  = LOAD_DELAY;
                            rep_d   = 1'b1;
                        end
                    end
                    ST_DELAY, ST_PERIOD: begin
                        if (rcnt_q == '0) begin
                            state_d = ST_PERIOD;
                            rcnt_d  = LOAD_PERIOD;
                            rep_d   = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                rep_q   <= rep_d;
            end
        end

        assign repeat_o = rep_q;
    end else begin : g_no_rpt
        assign repeat_o = 1'b0;
    end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronises and debounces every player button and panel switch into the
// system clock domain and produces registered press / release / auto-repeat
// pulses for the game controller.
//
// Ports:
//   CLK   : 40 MHz system clock
//   RESET : asynchronous, active-high reset
//   bus   : input_conditioner_if.slave
//             RAW_IN  (in)  raw pad levels
//             LEVEL   (out) debounced levels
//             PRESS   (out) one-cycle rise pulses
//             RELEASE (out) one-cycle fall pulses
//             REPEAT  (out) press + auto-repeat pulses, 0 outside REPEAT_MASK
//
// Channel bit positions follow the CH_* indices in breakout_pkg.
// -----------------------------------------------------------------------------
module input_conditioner
    import breakout_pkg::*;
#(
    parameter int                  CHANNELS        = NUM_CHANNELS,
    parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = CHANNELS'(DEF_REPEAT_MASK),
    parameter int                  REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                  REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLK,
    input  logic                RESET,
    input_conditioner_if.slave  bus
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("input_conditioner: CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .CLK       (CLK),
            .RESET     (RESET),
            .raw_i     (bus.RAW_IN[i]),
            .level_o   (bus.LEVEL[i]),
            .press_o   (bus.PRESS[i]),
            .release_o (bus.RELEASE[i]),
            .repeat_o  (bus.REPEAT[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    import breakout_pkg::*;

    typedef struct {
        int         edge_n;
        logic [6:0] lmask;
        logic [6:0] lval;
        logic [6:0] press;
        logic [6:0] rel;
        logic [6:0] rep;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   c;
    ev_t  sb[$];
    ev_t  cur;
    logic [6:0] exp_level;
    logic [6:0] ep, er, eq;

    input_conditioner_if #(.CHANNELS(7)) bus ();

    input_conditioner #(
        .CHANNELS        (7),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_MASK     (7'b0000011),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at edge %0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int e, input logic [6:0] lmask, input logic [6:0] lval,
                           input logic [6:0] press, input logic [6:0] rel, input logic [6:0] rep);
        ev_t x;
        x.edge_n = e;
        x.lmask  = lmask;
        x.lval   = lval;
        x.press  = press;
        x.rel    = rel;
        x.rep    = rep;
        sb.push_back(x);
    endtask

    // Output monitor: compares every cycle against the scoreboard; cycles
    // without a scheduled event must show no pulses and an unchanged level.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            exp_level = '0;
            chk("rst_level",   bus.LEVEL,   7'd0);
            chk("rst_press",   bus.PRESS,   7'd0);
            chk("rst_release", bus.RELEASE, 7'd0);
            chk("rst_repeat",  bus.REPEAT,  7'd0);
        end else begin
            ep = '0;
            er = '0;
            eq = '0;
            if (sb.size() > 0) begin
                checks++;
                assert (sb[0].edge_n >= cyc) else begin
                    errors++;
                    $error("FAIL sb_missed event for edge %0d still pending at edge %0d", sb[0].edge_n, cyc);
                    void'(sb.pop_front());
                end
            end
            if (sb.size() > 0 && sb[0].edge_n == cyc) begin
                cur = sb.pop_front();
                exp_level = (exp_level & ~cur.lmask) | (cur.lval & cur.lmask);
                ep = cur.press;
                er = cur.rel;
                eq = cur.rep;
            end
            chk("level",   bus.LEVEL,   exp_level);
            chk("press",   bus.PRESS,   ep);
            chk("release", bus.RELEASE, er);
            chk("repeat",  bus.REPEAT,  eq);
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_level  = '0;
        rst        = 1'b1;
        bus.RAW_IN = '0;

        // Reset state
        tick(3);
        chk("reset_level", bus.LEVEL,   7'd0);
        chk("reset_press", bus.PRESS,   7'd0);
        chk("reset_rel",   bus.RELEASE, 7'd0);
        chk("reset_rep",   bus.REPEAT,  7'd0);
        rst = 1'b0;
        tick(3);

        // Clean press/release on LEFT; fall lands on a repeat expiry (k+25)
        c = cyc;
        bus.RAW_IN[CH_LEFT] = 1'b1;
        push_ev(c + 6,  7'h01, 7'h01, 7'h01, 7'h00, 7'h01);
        push_ev(c + 16, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01);
        push_ev(c + 21, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01);
        push_ev(c + 26, 7'h01, 7'h00, 7'h00, 7'h01, 7'h00);
        tick(20);
        bus.RAW_IN[CH_LEFT] = 1'b0;
        tick(12);

        // Bounce rejection on A: final stable capture at k+8
        c = cyc;
        push_ev(c + 14, 7'h04, 7'h04, 7'h04, 7'h00, 7'h00);
        bus.RAW_IN[CH_A] = 1'b1;
        tick(2);
        bus.RAW_IN[CH_A] = 1'b0;
        tick(2);
        bus.RAW_IN[CH_A] = 1'b1;
        tick(2);
        bus.RAW_IN[CH_A] = 1'b0;
        tick(2);
        bus.RAW_IN[CH_A] = 1'b1;
        tick(12);
        c = cyc;
        bus.RAW_IN[CH_A] = 1'b0;
        push_ev(c + 6, 7'h04, 7'h00, 7'h00, 7'h04, 7'h00);
        tick(10);

        // Auto-repeat on RIGHT, none on B; p = c+6
        c = cyc;
        bus.RAW_IN[CH_RIGHT] = 1'b1;
        bus.RAW_IN[CH_B]     = 1'b1;
        push_ev(c + 6,  7'h0A, 7'h0A, 7'h0A, 7'h00, 7'h02);
        push_ev(c + 16, 7'h00, 7'h00, 7'h00, 7'h00, 7'h02);
        push_ev(c + 21, 7'h00, 7'h00, 7'h00, 7'h00, 7'h02);
        push_ev(c + 26, 7'h00, 7'h00, 7'h00, 7'h00, 7'h02);
        push_ev(c + 28, 7'h0A, 7'h00, 7'h00, 7'h0A, 7'h00);
        tick(22);
        bus.RAW_IN[CH_RIGHT] = 1'b0;
        bus.RAW_IN[CH_B]     = 1'b0;
        tick(12);

        // Release/expiry collision on RIGHT at p+15
        c = cyc;
        bus.RAW_IN[CH_RIGHT] = 1'b1;
        push_ev(c + 6,  7'h02, 7'h02, 7'h02, 7'h00, 7'h02);
        push_ev(c + 16, 7'h00, 7'h00, 7'h00, 7'h00, 7'h02);
        push_ev(c + 21, 7'h02, 7'h00, 7'h00, 7'h02, 7'h00);
        tick(15);
        bus.RAW_IN[CH_RIGHT] = 1'b0;
        tick(25);

        // Reset mid-operation: PAUSE up, RESET channel at counter=3
        c = cyc;
        bus.RAW_IN[CH_PAUSE] = 1'b1;
        push_ev(c + 6, 7'h20, 7'h20, 7'h20, 7'h00, 7'h00);
        tick(10);
        bus.RAW_IN[CH_RESET] = 1'b1;
        tick(5);
        rst = 1'b1;
        #1;
        chk("async_level", bus.LEVEL,   7'd0);
        chk("async_press", bus.PRESS,   7'd0);
        chk("async_rel",   bus.RELEASE, 7'd0);
        chk("async_rep",   bus.REPEAT,  7'd0);
        tick(2);
        rst = 1'b0;
        c = cyc;
        push_ev(c + 6, 7'h30, 7'h30, 7'h30, 7'h00, 7'h00);
        tick(10);
        c = cyc;
        bus.RAW_IN = '0;
        push_ev(c + 6, 7'h30, 7'h00, 7'h00, 7'h30, 7'h00);
        tick(10);

        // Simultaneous rise on all channels
        c = cyc;
        bus.RAW_IN = 7'h7F;
        push_ev(c + 6,  7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h03);
        push_ev(c + 12, 7'h7F, 7'h00, 7'h00, 7'h7F, 7'h00);
        tick(6);
        bus.RAW_IN = '0;
        tick(14);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain pending=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
